// File: rtl/cordic_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cordic_seq : two-channel initiator for the shared serial CORDIC engine
// Revision   : 1.0
// ---------------------------------------------------------------------------
module cordic_seq #(
    parameter int TIMEOUT = 63,
    parameter int TW      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_x,
    input  logic [15:0] a_y,
    output logic        a_ovalid,
    output logic [15:0] a_mag,
    output logic [15:0] a_phase,
    output logic [15:0] a_dphase,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_mag,
    input  logic [15:0] b_phase,
    output logic        b_ovalid,
    output logic [15:0] b_i,
    output logic [15:0] b_q,
    output logic [15:0] eng_xi,
    output logic [15:0] eng_yi,
    output logic [15:0] eng_zi,
    output logic        eng_mi,
    output logic        eng_load,
    input  logic [15:0] eng_xo,
    input  logic [15:0] eng_yo,
    input  logic [15:0] eng_zo,
    input  logic        eng_mo,
    input  logic        eng_rdy,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // The counter is cleared during LOAD, so it lags the load strobe by one
    // cycle; giving up at TIMEOUT-2 makes err appear TIMEOUT cycles after eng_load.
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 2);

    logic [1:0]    state;
    logic          a_full, b_full;
    logic [15:0]   a_x_h, a_y_h, b_mag_h, b_phase_h;
    logic          tag;        // 0 = channel A, 1 = channel B (matches eng_mi)
    logic          last_b;
    logic [TW-1:0] cnt;
    logic [15:0]   prev_phase;

    assign a_ready  = ~a_full;
    assign b_ready  = ~b_full;
    assign eng_load = (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_full     <= 1'b0;
            b_full     <= 1'b0;
            a_x_h      <= '0;
            a_y_h      <= '0;
            b_mag_h    <= '0;
            b_phase_h  <= '0;
            tag        <= 1'b0;
            last_b     <= 1'b1;
            cnt        <= '0;
            prev_phase <= '0;
            eng_xi     <= '0;
            eng_yi     <= '0;
            eng_zi     <= '0;
            eng_mi     <= 1'b0;
            a_ovalid   <= 1'b0;
            a_mag      <= '0;
            a_phase    <= '0;
            a_dphase   <= '0;
            b_ovalid   <= 1'b0;
            b_i        <= '0;
            b_q        <= '0;
            err        <= 1'b0;
        end else begin
            a_ovalid <= 1'b0;
            b_ovalid <= 1'b0;

            if (a_valid && !a_full) begin
                a_full <= 1'b1;
                a_x_h  <= a_x;
                a_y_h  <= a_y;
            end
            if (b_valid && !b_full) begin
                b_full    <= 1'b1;
                b_mag_h   <= b_mag;
                b_phase_h <= b_phase;
            end

            case (state)
                S_IDLE: begin
                    if (a_full || b_full) begin
                        // A wins when it is alone or when B was served last
                        if (a_full && (!b_full || last_b)) begin
                            tag    <= 1'b0;
                            eng_xi <= a_x_h;
                            eng_yi <= a_y_h;
                            eng_zi <= '0;
                            eng_mi <= 1'b0;
                        end else begin
                            tag    <= 1'b1;
                            eng_xi <= b_mag_h;
                            eng_yi <= '0;
                            eng_zi <= b_phase_h;
                            eng_mi <= 1'b1;
                        end
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt    <= '0;
                    last_b <= tag;
                    if (tag) b_full <= 1'b0;
                    else     a_full <= 1'b0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_rdy) begin
                        if (eng_mo != tag) err <= 1'b1;
                        if (!tag) begin
                            a_mag      <= eng_xo;
                            a_phase    <= eng_zo;
                            a_dphase   <= eng_zo - prev_phase;
                            prev_phase <= eng_zo;
                            a_ovalid   <= 1'b1;
                        end else begin
                            b_i      <= eng_xo;
                            b_q      <= eng_yo;
                            b_ovalid <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cordic_seq.md
Name: cordic_seq

Overview:
- Initiator/sequencer for the shared 16-bit serial CORDIC engine. It owns the engine's load/rdy interface and multiplexes two client channels through the one engine, with one operation in flight at a time.
- Channel A requests vector mode (I/Q to magnitude/phase) and also gets an FM-discriminator phase difference.
- Channel B requests rotate mode (magnitude/phase to I/Q).
- Sits between the receive/transmit DSP chains and the engine instance.

Parameters:
- TIMEOUT, 63: clock cycles allowed from eng_load to eng_rdy before the operation is aborted.
- TW, 6: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  master clock
- rst  in  1  synchronous active-high reset
- a_valid  in  1  channel A request valid
- a_ready  out  1  channel A holding register empty
- a_x, a_y  in  16  channel A I/Q, signed two's complement
- a_ovalid  out  1  one-cycle pulse: channel A result valid
- a_mag, a_phase  out  16  magnitude and phase (full scale = ±Pi)
- a_dphase  out  16  a_phase minus previous a_phase, mod 2^16
- b_valid  in  1  channel B request valid
- b_ready  out  1  channel B holding register empty
- b_mag, b_phase  in  16  channel B magnitude and phase
- b_ovalid  out  1  one-cycle pulse: channel B result valid
- b_i, b_q  out  16  rotated I/Q
- eng_xi, eng_yi, eng_zi  out  16  engine operands
- eng_mi  out  1  0 = vector mode, 1 = rotate mode
- eng_load  out  1  one-cycle load strobe
- eng_xo, eng_yo, eng_zo  in  16  engine results
- eng_mo  in  1  mode echoed by the engine
- eng_rdy  in  1  engine result strobe
- err  out  1  sticky: timeout or mode mismatch

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - a_ready = b_ready = 1.
  - a_ovalid = b_ovalid = eng_load = err = 0.
  - All data outputs, eng_* operands and the previous-phase register are 0.
  - State = IDLE; last-served = B, so A wins the first tie.
- Holding registers (one entry per channel):
  - A transfer occurs on valid & ready; ready drops the next cycle.
  - The register frees (ready = 1) on the cycle after that channel's LOAD.
  - A new request may be accepted while that channel's previous operation is still in WAIT.
- FSM states: IDLE, LOAD, WAIT.
  - IDLE: if any holding register is full, go to LOAD. Arbitration:
    - Only one full: serve it.
    - Both full: serve the channel not last served.
    - Register the operands and tag = served channel.
    - Channel A: eng_xi = a_x, eng_yi = a_y, eng_zi = 0, eng_mi = 0.
    - Channel B: eng_xi = b_mag, eng_yi = 0, eng_zi = b_phase, eng_mi = 1.
  - LOAD: eng_load = 1 for exactly this cycle; clear the timeout counter; update last-served; go to WAIT.
  - WAIT:
    - On eng_rdy:
      - Tag = A: a_mag = eng_xo, a_phase = eng_zo, a_dphase = eng_zo − prev (16-bit wrap); prev updated to eng_zo; a_ovalid pulses the next cycle.
      - Tag = B: b_i = eng_xo, b_q = eng_yo; b_ovalid pulses the next cycle.
      - Return to IDLE.
    - If the counter reaches TIMEOUT without eng_rdy: set err, emit no result, return to IDLE.
- Issue rate: IDLE follows the rdy cycle, so the next LOAD is at least 2 cycles after eng_rdy.
- eng_rdy outside WAIT: ignored.
- eng_mo ≠ tag on eng_rdy: set err; the result is still routed by tag.
- err clears only on reset.
- Result outputs hold their values until the next result for that channel.
- a_dphase:
  - The first result after reset is taken against prev = 0.
  - Wrap example: 0x7FF0 → 0x8010 gives 0x0020.
- Reset mid-operation returns to the reset state on the next edge. Any later stray eng_rdy is ignored because the FSM is in IDLE.
- Operand registers change only in IDLE when a transfer is scheduled; they are stable during LOAD.

Test Plan:
- Single A request x=0x4000, y=0: exactly one eng_load with eng_mi=0, eng_zi=0. The engine model returns xo=0x4000, zo=0x0000, mo=0 → a_ovalid one cycle after eng_rdy; a_mag=0x4000, a_phase=0, a_dphase=0.
- Two A results with zo=0x7FF0 then 0x8010 → second a_dphase = 0x0020.
- A and B valid on the same cycle after reset → A is loaded first, then B (eng_mi=1, eng_xi=b_mag, eng_yi=0, eng_zi=b_phase). Holding both full continuously → strict A/B alternation.
- B request with the engine model never asserting rdy → err=1 exactly TIMEOUT cycles after eng_load, b_ovalid never pulses, FSM is back in IDLE. A following A request completes normally.
- Tag-A operation with the model returning eng_mo=1 → err=1, and the result still appears on the a_* outputs.
- rst asserted in WAIT, then a stray eng_rdy → all outputs at reset values, no ovalid pulse, a_ready = b_ready = 1.
